// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder buffer: bit reversal,
// reader state encoding and the default transform size.
package fft_pkg;

    localparam int unsigned FFT_N_LOG2    = 6;
    localparam int unsigned BITREV_MAX    = 16;
    localparam int unsigned BITREV_IDX_W  = $clog2(BITREV_MAX);

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;

    // Reverse the low n_log2 bits of value; upper bits of the result are zero.
    function automatic logic [BITREV_MAX-1:0] bitrev(
        input logic [BITREV_MAX-1:0] value,
        input int unsigned           n_log2
    );
        logic [BITREV_MAX-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < BITREV_MAX; i++) begin
            if (i < n_log2) begin
                r[BITREV_IDX_W'(n_log2 - 1 - i)] = value[BITREV_IDX_W'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reorder_ram.sv
// Simple dual-port frame store: one synchronous write port and one
// registered read port; address is {bank, index}.
module reorder_ram #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 46
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_reorder_buf.sv
// Ping-pong reorder buffer: frames arrive in bit-reversed bin order, are
// stored at bitrev(write count) and streamed out in natural order.
module fft_reorder_buf
    import fft_pkg::*;
#(
    parameter int unsigned BW     = 23,
    parameter int unsigned N_LOG2 = FFT_N_LOG2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inValid,
    input  logic [BW-1:0]     inReal,
    input  logic [BW-1:0]     inImag,
    output logic              outValid,
    output logic [BW-1:0]     outReal,
    output logic [BW-1:0]     outImag,
    output logic [N_LOG2-1:0] outIdx,
    output logic              outSof,
    output logic              outEof,
    output logic              ovf
);

    localparam int unsigned AW = N_LOG2 + 1;
    localparam int unsigned DW = 2 * BW;

    logic [N_LOG2-1:0] wr_cnt_q;
    logic              wr_bank_q;
    logic [1:0]        full_q;
    logic [1:0]        full_d;

    rd_state_e         state_q;
    rd_state_e         state_d;
    logic [N_LOG2-1:0] rd_cnt_q;
    logic [N_LOG2-1:0] rd_cnt_d;
    logic              rd_bank_q;
    logic              rd_bank_d;
    logic              rd_en_c;
    logic              release_c;

    logic              s1_valid_q;
    logic [N_LOG2-1:0] s1_idx_q;
    logic [DW-1:0]     rd_data;

    logic [N_LOG2-1:0] wr_idx_c;
    logic              wr_last_c;
    logic              ovf_hit_c;

    assign wr_idx_c  = N_LOG2'(bitrev(BITREV_MAX'(wr_cnt_q), N_LOG2));
    assign wr_last_c = inValid && (wr_cnt_q == '1);
    // A bank released by the reader in this same cycle is free to refill.
    assign ovf_hit_c = inValid && full_q[wr_bank_q]
                       && !(release_c && (rd_bank_q == wr_bank_q));

    reorder_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (inValid && !reset),
        .wr_addr ({wr_bank_q, wr_idx_c}),
        .wr_data ({inReal, inImag}),
        .rd_en   (rd_en_c),
        .rd_addr ({rd_bank_q, rd_cnt_q}),
        .rd_data (rd_data)
    );

    // Reader next-state: stream a full bank, chain into the other without a bubble.
    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_en_c   = 1'b0;
        release_c = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d  = RD_READ;
                    rd_cnt_d = '0;
                end
            end
            RD_READ: begin
                rd_en_c  = 1'b1;
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == '1) begin
                    release_c = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    rd_cnt_d  = '0;
                    state_d   = full_q[~rd_bank_q] ? RD_READ : RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // Bank ownership flags; set by a completing write, cleared by the reader.
    always_comb begin
        full_d = full_q;
        if (release_c) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_last_c) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q   <= '0;
            wr_bank_q  <= 1'b0;
            full_q     <= '0;
            state_q    <= RD_IDLE;
            rd_cnt_q   <= '0;
            rd_bank_q  <= 1'b0;
            ovf        <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            outValid   <= 1'b0;
            outReal    <= '0;
            outImag    <= '0;
            outIdx     <= '0;
            outSof     <= 1'b0;
            outEof     <= 1'b0;
        end else begin
            full_q    <= full_d;
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_bank_q <= rd_bank_d;
            if (inValid) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
                if (wr_last_c) begin
                    wr_bank_q <= ~wr_bank_q;
                end
            end
            if (ovf_hit_c) begin
                ovf <= 1'b1;
            end
            // Side-band tracks the RAM read latency, then everything is registered once more.
            s1_valid_q <= rd_en_c;
            s1_idx_q   <= rd_cnt_q;
            outValid   <= s1_valid_q;
            outIdx     <= s1_valid_q ? s1_idx_q : '0;
            outSof     <= s1_valid_q && (s1_idx_q == '0);
            outEof     <= s1_valid_q && (s1_idx_q == '1);
            outReal    <= s1_valid_q ? rd_data[DW-1:BW] : '0;
            outImag    <= s1_valid_q ? rd_data[BW-1:0]  : '0;
        end
    end

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Randomized bench for fft_reorder_buf (N=8): a frame-level model predicts
// every natural-order output bin and the cycle on which it must appear.
module tb_fft_reorder_buf;

    localparam int unsigned BW     = 23;
    localparam int unsigned N_LOG2 = 3;
    localparam int          N      = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              inValid;
    logic [BW-1:0]     inReal;
    logic [BW-1:0]     inImag;
    logic              outValid;
    logic [BW-1:0]     outReal;
    logic [BW-1:0]     outImag;
    logic [N_LOG2-1:0] outIdx;
    logic              outSof;
    logic              outEof;
    logic              ovf;

    fft_reorder_buf #(.BW(BW), .N_LOG2(N_LOG2)) dut (
        .clk      (clk),
        .reset    (reset),
        .inValid  (inValid),
        .inReal   (inReal),
        .inImag   (inImag),
        .outValid (outValid),
        .outReal  (outReal),
        .outImag  (outImag),
        .outIdx   (outIdx),
        .outSof   (outSof),
        .outEof   (outEof),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] re;
        logic [BW-1:0] im;
        int            idx;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [BW-1:0] fr_re[N];
    logic [BW-1:0] fr_im[N];
    int            wcnt       = 0;
    int            last_sched = 0;
    int            cyc        = 0;
    int            n_checks   = 0;
    int            n_errors   = 0;
    bit            mon_en     = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    function automatic int br(input int j);
        return ((j & 1) << 2) | (j & 2) | ((j >> 2) & 1);
    endfunction

    // Frame model: bin k of a completed frame is the sample that arrived in slot br(k).
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            exp_q.delete();
            wcnt       = 0;
            last_sched = 0;
        end else if (inValid) begin
            fr_re[wcnt] = inReal;
            fr_im[wcnt] = inImag;
            wcnt++;
            if (wcnt == N) begin
                int start;
                start = (cyc + 3 > last_sched + 1) ? cyc + 3 : last_sched + 1;
                for (int k = 0; k < N; k++) begin
                    exp_t e;
                    e.re  = fr_re[br(k)];
                    e.im  = fr_im[br(k)];
                    e.idx = k;
                    e.cyc = start + k;
                    exp_q.push_back(e);
                end
                last_sched = start + N - 1;
                wcnt       = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (outValid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", {63'd0, outValid}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_real", outReal, mon_e.re);
                    check("out_imag", outImag, mon_e.im);
                    check("out_idx",  outIdx,  mon_e.idx);
                    check("out_sof",  outSof,  mon_e.idx == 0);
                    check("out_eof",  outEof,  mon_e.idx == N - 1);
                    check("out_cycle", cyc,    mon_e.cyc);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                check("out_missing", {63'd0, outValid}, 64'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [BW-1:0] re, input logic [BW-1:0] im);
        inValid = v;
        inReal  = re;
        inImag  = im;
        tick();
        inValid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick();
        repeat (3) tick();
        check(tag, exp_q.size(), 0);
        check({tag, "_ovf"}, {63'd0, ovf}, 64'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset   = 1'b1;
        inValid = 1'b0;
        inReal  = '0;
        inImag  = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_valid", {63'd0, outValid}, 64'd0);
        check("rst_real",  outReal, 64'd0);
        check("rst_imag",  outImag, 64'd0);
        check("rst_idx",   outIdx,  64'd0);
        check("rst_sof",   {63'd0, outSof}, 64'd0);
        check("rst_eof",   {63'd0, outEof}, 64'd0);
        check("rst_ovf",   {63'd0, ovf},    64'd0);
        #1;
        reset = 1'b0;
        tick();

        // Single frame, continuous, imag = -real
        for (int j = 0; j < N; j++) put(1'b1, BW'(br(j)), BW'(-br(j)));
        drain("t1_drain");

        // Three back-to-back frames
        for (int f = 0; f < 3; f++)
            for (int j = 0; j < N; j++) put(1'b1, BW'(8 * f + br(j)), BW'($urandom));
        drain("t2_drain");

        // One frame with a gap every other cycle
        for (int j = 0; j < N; j++) begin
            put(1'b0, '0, '0);
            put(1'b1, BW'(br(j)), BW'(-br(j)));
        end
        drain("t3_drain");

        // Random valid pattern and random data over several frames
        for (int n = 0; n < 5 * N; ) begin
            if ($urandom_range(0, 3) != 0) begin
                put(1'b1, BW'($urandom), BW'($urandom));
                n++;
            end else begin
                put(1'b0, BW'($urandom), BW'($urandom));
            end
        end
        drain("rand_drain");

        // Reset after a partial frame, then a fresh frame
        for (int j = 0; j < 5; j++) put(1'b1, BW'($urandom), BW'($urandom));
        pulse_reset();
        for (int j = 0; j < N; j++) put(1'b1, BW'(100 + br(j)), BW'(j));
        drain("t4_drain");

        // Reset while streaming at outIdx 3
        for (int j = 0; j < N; j++) put(1'b1, BW'($urandom), BW'($urandom));
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (outValid && outIdx == 3) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_idx3_seen", {63'd0, found}, 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_valid", {63'd0, outValid}, 64'd0);
        check("t6_real",  outReal, 64'd0);
        check("t6_imag",  outImag, 64'd0);
        check("t6_idx",   outIdx,  64'd0);
        check("t6_sof",   {63'd0, outSof}, 64'd0);
        check("t6_eof",   {63'd0, outEof}, 64'd0);
        repeat (20) tick();
        for (int j = 0; j < N; j++) put(1'b1, BW'(200 + br(j)), BW'($urandom));
        drain("t6_drain");

        // Overflow: both banks held full while another sample arrives
        mon_en = 1'b0;
        force dut.full_q = 2'b11;
        put(1'b1, BW'($urandom), BW'($urandom));
        check("t5_ovf_set", {63'd0, ovf}, 64'd1);
        release dut.full_q;
        repeat (20) tick();
        check("t5_ovf_sticky", {63'd0, ovf}, 64'd1);
        pulse_reset();
        check("t5_ovf_cleared", {63'd0, ovf}, 64'd0);
        @(negedge clk);
        mon_en = 1'b1;
        for (int j = 0; j < N; j++) put(1'b1, BW'($urandom), BW'($urandom));
        drain("t5_after_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_reorder_buf.md
Name: fft_reorder_buf

Overview:
- Output-side reorder buffer for the radix-2 SDF FFT pipeline. It sits directly after the last butterfly stage.
- The pipeline emits bins in bit-reversed order. This block writes each frame into one bank of a ping-pong buffer at address bitrev(write count), then reads the bank sequentially, so bins leave in natural order 0..N-1.
- It is the reader/consumer end of the last-stage output stream.

Parameters:
- BW, 23, sample width per component; matches the last-stage output width (stage BW + 1).
- N_LOG2, 6, log2 of FFT size; N = 2^N_LOG2 bins per frame.

Ports:
- clk, in, 1, clock; all logic on rising edge.
- reset, in, 1, synchronous active-high reset.
- inValid, in, 1, inReal/inImag carry one bin this cycle.
- inReal, in, BW, bin real part, bit-reversed frame order, two's complement.
- inImag, in, BW, bin imaginary part.
- outValid, out, 1, outReal/outImag/outIdx valid.
- outReal, out, BW, bin real part, natural order.
- outImag, out, BW, bin imaginary part.
- outIdx, out, N_LOG2, bin index of the current output (0..N-1).
- outSof, out, 1, high with outIdx==0.
- outEof, out, 1, high with outIdx==N-1.
- ovf, out, 1, sticky overflow error flag.

Behaviour:
- Reset: all outputs 0; wr_cnt=0; wr_bank=0; full[1:0]=0; reader FSM in IDLE; rd_cnt=0; ovf=0.
- Reset mid-frame: any partial frame and any pending full bank are discarded; no further outputs appear until a new complete frame is written.
- Write side:
  - On each inValid, store {inReal,inImag} at bank wr_bank, address bitrev(wr_cnt).
  - Then wr_cnt++. Gaps (inValid=0) hold wr_cnt.
  - When wr_cnt==N-1 with inValid: set full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
- Overflow: if a write targets a bank whose full bit is still set (reader has not released it), set ovf (sticky until reset). The sample is still written; data integrity is not guaranteed after that.
- Reader FSM:
  - IDLE: if full[rd_bank], go to READ with rd_cnt=0.
  - READ: issue a RAM read of rd_bank address rd_cnt every cycle; rd_cnt++.
  - On issuing rd_cnt==N-1: clear full[rd_bank], toggle rd_bank, return to IDLE. If the other bank is already full, go straight back to READ with no bubble.
- Read data path:
  - RAM read is synchronous (1 cycle). Data plus index/sof/eof are registered once more at the output.
  - outValid is therefore 2 cycles after read issue.
- Latency:
  - Edge E captures the last bin of a frame.
  - Bin 0 appears on outputs after edge E+3.
  - The frame then streams N consecutive cycles, outValid=1 throughout, no gaps.
- Throughput: a continuous input (inValid always 1) produces a continuous output with no ovf.
- Simultaneous events: a write completing bank A in the same cycle the reader releases bank B is legal; both flag updates take effect.
- Width: data passes through unmodified; no rounding or saturation.

Decomposition:
- Package fft_pkg holds:
  - function bitrev(value, N_LOG2);
  - reader FSM state encoding (IDLE, READ);
  - constant for the default FFT size.
- One sub-module: reorder_ram.
  - Simple dual-port, 2*N words x 2*BW bits.
  - One synchronous write port, one synchronous-read port.
  - Address = {bank, index}.
- Top level holds the counters, full flags, FSM and output registers.

Test Plan (N_LOG2=3, N=8, BW=23):
1. Single frame, inValid continuous, inReal = 0,4,2,6,1,5,3,7 and inImag = -inReal -> outReal 0..7 and outImag 0,-1..-7 on 8 consecutive cycles; outIdx 0..7; outSof on idx 0; outEof on idx 7; first output after edge E+3; ovf=0.
2. Three back-to-back frames (24 continuous inputs, frame f real = 8f + bitrev(j)) -> 24 contiguous outputs, values 0..23 in order, no outValid gap, ovf=0.
3. Input with gaps (inValid=1 every other cycle) for one frame -> same natural-order output as test 1; output starts 3 edges after the 8th valid sample.
4. Reset asserted after 5 inputs, then a full frame of values 100 + bitrev(j) -> only 100..107 emitted; no stale samples appear.
5. Force overflow: hold the reader via a bench-forced full flag (or drive input with the RAM read stalled in a test config) so a third frame completes while both banks are full -> ovf=1, and it stays 1 until reset.
6. Reset asserted during READ at outIdx=3 -> next cycle outValid=0 and all outputs 0; outputs resume only after a new full frame.
